// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared definitions for the instruction-fetch sequencer:
//   - fetch_state_e : FSM state encoding (IDLE, REQ, WAIT, HOLD, DRAIN)
//   - npc_sel_e     : next-PC source select (pc+4, branch target, jump address)
//   - PC_STEP       : byte distance between sequential instructions
//   - DEFAULT_RESET_PC : default first fetch address
//   - npc_select()  : redirect priority (jump beats branch_taken)
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_PC4    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } npc_sel_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Jump wins when decode reports both a jump and a taken branch.
  function automatic npc_sel_e npc_select(input logic jump, input logic branch_taken);
    npc_sel_e sel;
    if (jump)              sel = SEL_JUMP;
    else if (branch_taken) sel = SEL_BRANCH;
    else                   sel = SEL_PC4;
    return sel;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles the instruction-memory request/response channel, the decode-side
//   instruction handshake with its redirect inputs, the control flush and the
//   consumed-instruction counter.
//   master : the fetch sequencer (drives imem request, instruction buffer,
//            fetch_cnt; receives imem response, decode and control inputs)
//   slave  : the surrounding system (imem + decode + control)
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int IMM_W = 16,
  parameter int JT_W  = 26
);

  // Instruction memory channel
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;

  // Decode channel
  logic              inst_valid;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              dec_ready;
  logic              branch_taken;
  logic [IMM_W-1:0]  branch_imm;
  logic              jump;
  logic [JT_W-1:0]   jump_target;

  // Control redirect
  logic              flush;
  logic [31:0]       flush_pc;

  // Statistics
  logic [31:0]       fetch_cnt;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_cnt,
    input  imem_ready, imem_rvalid, imem_rdata,
    input  dec_ready, branch_taken, branch_imm, jump, jump_target,
    input  flush, flush_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_cnt,
    output imem_ready, imem_rvalid, imem_rdata,
    output dec_ready, branch_taken, branch_imm, jump, jump_target,
    output flush, flush_pc
  );

endinterface

// File: rtl/fetch_sequencer_next_pc.sv
// -----------------------------------------------------------------------------
// Next-PC datapath for the fetch sequencer (purely combinational).
//   sign_extend  : i_in[IN_W] -> o_out[OUT_W], replicating the top bit
//   shift_left_2 : i_in[32]   -> o_out[32] = i_in << 2 (word to byte offset)
//   adder_32b    : i_a, i_b   -> o_sum, modulo 2^32
//   next_pc_unit : i_inst_pc, i_branch_imm, i_jump_target, i_branch_taken,
//                  i_jump -> o_next_pc
//                  pc4    = inst_pc + 4
//                  branch = pc4 + (sext(imm) << 2)
//                  jump   = {pc4[31:JT_W+2], jump_target, 2'b00}
// -----------------------------------------------------------------------------
module sign_extend #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  i_in,
  output logic [OUT_W-1:0] o_out
);
  assign o_out = {{(OUT_W-IN_W){i_in[IN_W-1]}}, i_in};
endmodule

module shift_left_2 (
  input  logic [31:0] i_in,
  output logic [31:0] o_out
);
  assign o_out = i_in << 2;
endmodule

module adder_32b (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  assign o_sum = i_a + i_b;
endmodule

module next_pc_unit
  import fetch_sequencer_pkg::*;
#(
  parameter int IMM_W = 16,
  parameter int JT_W  = 26
) (
  input  logic [31:0]      i_inst_pc,
  input  logic [IMM_W-1:0] i_branch_imm,
  input  logic [JT_W-1:0]  i_jump_target,
  input  logic             i_branch_taken,
  input  logic             i_jump,
  output logic [31:0]      o_next_pc
);

  logic [31:0] w_pc4;
  logic [31:0] w_imm_ext;
  logic [31:0] w_imm_bytes;
  logic [31:0] w_branch_addr;
  logic [31:0] w_jump_addr;

  adder_32b u_pc4_add (
    .i_a   (i_inst_pc),
    .i_b   (PC_STEP),
    .o_sum (w_pc4)
  );

  sign_extend #(.IN_W(IMM_W), .OUT_W(32)) u_imm_sext (
    .i_in  (i_branch_imm),
    .o_out (w_imm_ext)
  );

  shift_left_2 u_imm_shl (
    .i_in  (w_imm_ext),
    .o_out (w_imm_bytes)
  );

  adder_32b u_branch_add (
    .i_a   (w_pc4),
    .i_b   (w_imm_bytes),
    .o_sum (w_branch_addr)
  );

  // Jump keeps the 256 MB region of the delay-slot address (pc4), not of pc.
  assign w_jump_addr = {w_pc4[31:JT_W+2], i_jump_target, 2'b00};

  always_comb begin
    o_next_pc = w_pc4;
    case (npc_select(i_jump, i_branch_taken))
      SEL_JUMP:   o_next_pc = w_jump_addr;
      SEL_BRANCH: o_next_pc = w_branch_addr;
      default:    o_next_pc = w_pc4;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Multicycle instruction-fetch controller. Owns the PC, issues one
//   valid/ready request at a time to instruction memory, buffers the returned
//   word for decode and computes the next PC when decode consumes it.
//   Ports:
//     clk  : clock, all state on posedge
//     rst  : synchronous active-high reset
//     bus  : fetch_sequencer_if.master
//            imem_req/imem_addr/imem_ready  - fetch request handshake
//            imem_rvalid/imem_rdata         - fetch response
//            inst_valid/inst/inst_pc        - buffered instruction to decode
//            dec_ready                      - decode consumes the instruction
//            branch_taken/branch_imm/jump/jump_target - redirect with consume
//            flush/flush_pc                 - control redirect, any state
//            fetch_cnt                      - consumed-instruction count
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IMM_W    = 16,
  parameter int          JT_W     = 26
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         r_inst_valid;
  logic         w_inst_valid_nxt;
  logic [31:0]  r_inst;
  logic [31:0]  r_inst_pc;
  logic [31:0]  r_fetch_cnt;
  logic         w_load_inst;
  logic         w_cnt_inc;
  logic [31:0]  w_redirect_pc;

  next_pc_unit #(.IMM_W(IMM_W), .JT_W(JT_W)) u_next_pc (
    .i_inst_pc      (r_inst_pc),
    .i_branch_imm   (bus.branch_imm),
    .i_jump_target  (bus.jump_target),
    .i_branch_taken (bus.branch_taken),
    .i_jump         (bus.jump),
    .o_next_pc      (w_redirect_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc    <= 32'd0;
      r_fetch_cnt  <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      if (w_load_inst) begin
        r_inst    <= bus.imem_rdata;
        r_inst_pc <= r_pc;
      end
      if (w_cnt_inc) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_inst_valid_nxt = r_inst_valid;
    w_load_inst      = 1'b0;
    w_cnt_inc        = 1'b0;

    if (bus.flush) begin
      // Flush beats any consume/redirect and never counts as a consume.
      w_pc_nxt         = bus.flush_pc;
      w_inst_valid_nxt = 1'b0;
      case (r_state)
        // A request already accepted by imem must still have its response
        // swallowed, unless that response is arriving right now.
        ST_WAIT:  w_state_nxt = bus.imem_rvalid ? ST_REQ : ST_DRAIN;
        // Drain keeps waiting for its response; if the response lands in the
        // same cycle as the flush, the drain is complete.
        ST_DRAIN: w_state_nxt = bus.imem_rvalid ? ST_REQ : ST_DRAIN;
        default:  w_state_nxt = ST_REQ;
      endcase
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_REQ;
        ST_REQ: begin
          if (bus.imem_ready) w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            w_load_inst      = 1'b1;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Redirect inputs only matter in the consume cycle; the next pc is
          // ready in time for the following REQ, so redirects cost nothing.
          if (bus.dec_ready) begin
            w_cnt_inc        = 1'b1;
            w_inst_valid_nxt = 1'b0;
            w_pc_nxt         = w_redirect_pc;
            w_state_nxt      = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (bus.imem_rvalid) w_state_nxt = ST_REQ;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign bus.imem_req   = (r_state == ST_REQ);
  assign bus.imem_addr  = r_pc;
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst       = r_inst;
  assign bus.inst_pc    = r_inst_pc;
  assign bus.fetch_cnt  = r_fetch_cnt;

endmodule
